// File: rtl/simon_game_ctrl.sv
// Simon memory-game controller: loads a 32-step colour sequence, plays it back
// one extra step per round, and checks the player's presses against it.
module simon_game_ctrl #(
  parameter int SHOW_ON  = 4,
  parameter int SHOW_OFF = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] colour_in,
  input  logic       mem_load,
  input  logic [7:0] mem_in,
  output logic       gen_en,
  output logic [3:0] colour_out,
  output logic [5:0] round,
  output logic [2:0] state,
  output logic       win,
  output logic       lose
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHOW  = 3'd2,
    INPUT = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } state_e;

  localparam int SW = $clog2(SHOW_ON + SHOW_OFF + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] PH_LAST = SW'(SHOW_ON + SHOW_OFF - 1);
  localparam logic [SW-1:0] PH_ON   = SW'(SHOW_ON);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  function automatic logic [3:0] dec(input logic [1:0] c);
    case (c)
      2'b00:   dec = 4'b0001;
      2'b01:   dec = 4'b0010;
      2'b10:   dec = 4'b0100;
      default: dec = 4'b1000;
    endcase
  endfunction

  state_e          state_q;
  logic [2:0]      byte_cnt_q;
  logic [4:0]      idx_q;
  logic [SW-1:0]   ph_q;
  logic [TW-1:0]   timer_q;
  logic [5:0]      round_q;
  logic            gen_en_q;
  logic [3:0]      colour_q;
  logic            start_prev_q;
  logic [3:0]      cin_prev_q;
  logic [1:0]      steps_q [32];

  logic          start_ev, press_ev, step_hit, last_step;
  logic [1:0]    cur_step;
  logic [SW-1:0] ph_d;

  assign start_ev  = start & ~start_prev_q;
  assign press_ev  = (colour_in != 4'b0000) && (cin_prev_q == 4'b0000);
  assign cur_step  = steps_q[idx_q];
  assign step_hit  = $onehot(colour_in) && (colour_in == dec(cur_step));
  assign last_step = ({1'b0, idx_q} == (round_q - 6'd1));
  assign ph_d      = ph_q + SW'(1);

  // Step storage is deliberately unreset; LOAD always rewrites all 32 steps.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && mem_load) begin
      for (int j = 0; j < 4; j++) steps_q[{byte_cnt_q, 2'(j)}] <= mem_in[2*j +: 2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      idx_q        <= '0;
      ph_q         <= '0;
      timer_q      <= '0;
      round_q      <= '0;
      gen_en_q     <= 1'b0;
      colour_q     <= '0;
      start_prev_q <= 1'b0;
      cin_prev_q   <= '0;
    end else begin
      start_prev_q <= start;
      cin_prev_q   <= colour_in;
      case (state_q)
        IDLE, WIN, LOSE: begin
          if (start_ev) begin
            state_q    <= LOAD;
            byte_cnt_q <= '0;
            gen_en_q   <= 1'b1;
            colour_q   <= '0;
          end
        end
        LOAD: begin
          if (mem_load) begin
            byte_cnt_q <= byte_cnt_q + 3'd1;
            if (byte_cnt_q == 3'd7) begin
              state_q  <= SHOW;
              gen_en_q <= 1'b0;
              round_q  <= 6'd1;
              idx_q    <= '0;
              ph_q     <= '0;
              colour_q <= dec(steps_q[0]);
            end
          end
        end
        SHOW: begin
          if (ph_q == PH_LAST) begin
            ph_q <= '0;
            if (last_step) begin
              state_q  <= INPUT;
              idx_q    <= '0;
              timer_q  <= '0;
              colour_q <= '0;
            end else begin
              idx_q    <= idx_q + 5'd1;
              colour_q <= dec(steps_q[idx_q + 5'd1]);
            end
          end else begin
            ph_q     <= ph_d;
            colour_q <= (ph_d < PH_ON) ? dec(cur_step) : 4'b0000;
          end
        end
        INPUT: begin
          colour_q <= colour_in;
          timer_q  <= timer_q + TW'(1);
          // A press wins over a timeout landing in the same cycle.
          if (press_ev) begin
            if (step_hit) begin
              timer_q <= '0;
              if (!last_step) begin
                idx_q <= idx_q + 5'd1;
              end else if (round_q == 6'd32) begin
                state_q  <= WIN;
                colour_q <= 4'b1111;
              end else begin
                state_q  <= SHOW;
                round_q  <= round_q + 6'd1;
                idx_q    <= '0;
                ph_q     <= '0;
                colour_q <= dec(steps_q[0]);
              end
            end else begin
              state_q  <= LOSE;
              colour_q <= '0;
            end
          end else if (timer_q == TO_LAST) begin
            state_q  <= LOSE;
            colour_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gen_en     = gen_en_q;
  assign colour_out = colour_q;
  assign round      = round_q;
  assign state      = state_q;
  assign win        = (state_q == WIN);
  assign lose       = (state_q == LOSE);

endmodule

// File: doc/simon_game_ctrl.md
SIMON_GAME_CTRL -- requirements
Module: simon_game_ctrl

Interface
REQ-001 Parameter SHOW_ON, default 4: cycles a colour is lit during playback.
REQ-002 Parameter SHOW_OFF, default 2: dark cycles after each lit colour.
REQ-003 Parameter TIMEOUT, default 64: cycles allowed per player press.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  start/restart request (level)
- colour_in  in  4  player buttons, one bit per colour
- mem_load  in  1  byte-valid strobe from sequence generator
- mem_in  in  8  generated sequence byte
- gen_en  out  1  requests sequence bytes from generator
- colour_out  out  4  one-hot LED drive
- round  out  6  current round length, 0..32
- state  out  3  FSM state code
- win  out  1  level, high in WIN
- lose  out  1  level, high in LOSE

Function
REQ-005 Storage SHALL be 32 steps x 2 bits; byte k (0..7) fills steps 4k..4k+3, step 4k+j = mem_in[2j+1:2j].
REQ-006 Step decode SHALL be 00->0001, 01->0010, 10->0100, 11->1000; the same map converts a press to a 2-bit code.
REQ-007 States and codes SHALL be IDLE=0, LOAD=1, SHOW=2, INPUT=3, WIN=4, LOSE=5.
REQ-008 Start SHALL be edge-detected: an event is start=1 with the previous-cycle sample 0.
REQ-009 IDLE: a start event -> LOAD; byte count cleared.
REQ-010 LOAD: gen_en=1; each cycle with mem_load=1 stores mem_in at the byte count and increments it.
REQ-011 LOAD: on the 8th stored byte, gen_en=0 from the next cycle; next state SHOW with round=1, step index=0.
REQ-012 mem_load outside LOAD, or beyond 8 bytes, SHALL be ignored.
REQ-013 SHOW: for steps 0..round-1, colour_out=decode(step) for SHOW_ON cycles, then 0000 for SHOW_OFF cycles; after the final OFF phase -> INPUT with index=0 and timer=0.
REQ-014 Presses SHALL be edge-detected: colour_in nonzero with the previous sample 0000; presses outside INPUT are ignored.
REQ-015 INPUT: colour_out=colour_in (echo); timer increments each cycle.
REQ-016 A press with exactly one bit set that matches the current step SHALL increment the index and clear the timer.
REQ-017 A press with more than one bit set, or a one-hot mismatch, SHALL go to LOSE the next cycle.
REQ-018 Timer reaching TIMEOUT without a press -> LOSE; a press in the same cycle takes priority over timeout.
REQ-019 Correct press at index=round-1: round=32 -> WIN; otherwise round+1 -> SHOW at index 0.
REQ-020 WIN/LOSE: colour_out=1111 (WIN) or 0000 (LOSE); round holds; a start event -> LOAD with a fresh 8-byte load.
REQ-021 Start events in LOAD, SHOW or INPUT SHALL be ignored.
REQ-022 win/lose SHALL be pure state decodes; they are never both high.

Reset
REQ-023 With rst_n=0 at a clk edge, the block SHALL enter IDLE and set gen_en=0, colour_out=0000, round=0, win=0, lose=0, and clear counters, timer and edge-detect history.
REQ-024 Step storage is not cleared by reset; it is always rewritten in LOAD before use.
REQ-025 Reset mid-LOAD, SHOW or INPUT SHALL abort the operation with no residual gen_en or LED activity the next cycle.

Verification
REQ-026 Start event, 8 bytes 0xE4 -> SHOW round 1 shows 0001 for 4 cycles then 0000 for 2 cycles; state=3.
REQ-027 Bytes 0xE4, round 1: press 0001 -> round=2; SHOW displays 0001 then 0010; pressing 0001 then 0010 -> round=3.
REQ-028 In INPUT, press 0100 when the step is 00 -> lose=1, state=5, colour_out=0000; a start event -> state=1, gen_en=1.
REQ-029 In INPUT, no press for 64 cycles -> LOSE; a press 0011 -> LOSE.
REQ-030 All bytes 0x00, all 32 rounds answered with 0001 -> win=1, round=32, colour_out=1111.
REQ-031 rst_n=0 during SHOW round 5 -> next cycle state=0, colour_out=0000, round=0; 3 extra mem_load pulses in IDLE leave state=0.
